counter_seq_ctrl: RTL

COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

---
 rtl/counter_seq_pkg.sv | 14 +
 rtl/counter_4bit_ce.sv | 35 +++
 rtl/counter_seq_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter sequence controller.
// Holds the FSM state encoding and the default counter width.
package counter_seq_pkg;

  localparam int W_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/counter_4bit_ce.sv
// Datapath counter with a synchronous clear and a count enable.
// The clear input takes priority over the enable input.
module counter_4bit_ce #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencer running a counter for (repeat_cnt+1) passes of 0..terminal.
// Supports pause, abort and a one-cycle done pulse.
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         stop,
  input  logic         pause,
  input  logic [W-1:0] terminal,
  // "repeat" is a reserved word, so the pass-count input carries a suffix.
  input  logic [W-1:0] repeat_cnt,
  output logic [W-1:0] count,
  output logic [W-1:0] pass_cnt,
  output logic         busy,
  output logic         done,
  output logic [1:0]   state
);

  state_e       state_q, state_d;
  logic [W-1:0] pass_q, pass_d;
  logic [W-1:0] term_q, term_d;
  logic [W-1:0] rep_q, rep_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         cnt_clear;
  logic         cnt_enable;
  logic [W-1:0] cnt;

  counter_4bit_ce #(.W(W)) u_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .count   (cnt)
  );

  // Handshake: start is a request sampled only in IDLE; stop wins over start,
  // pause and counting in every state except DONE, which always returns to IDLE.
  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    term_d     = term_q;
    rep_d      = rep_q;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_clear = 1'b1;
        pass_d    = '0;
        if (start && !stop) begin
          term_d  = terminal;
          rep_d   = repeat_cnt;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          cnt_clear = 1'b1;
          pass_d    = '0;
          state_d   = S_IDLE;
        end else if (pause) begin
          state_d = S_HOLD;
        end else if (cnt != term_q) begin
          cnt_enable = 1'b1;
        end else if (pass_q != rep_q) begin
          cnt_clear = 1'b1;
          pass_d    = pass_q + 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_HOLD: begin
        if (stop) begin
          cnt_clear = 1'b1;
          pass_d    = '0;
          state_d   = S_IDLE;
        end else if (!pause) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        // Count still shows term_q this cycle; it clears on the way to IDLE.
        cnt_clear = 1'b1;
        pass_d    = '0;
        state_d   = S_IDLE;
      end
      default: begin
        cnt_clear = 1'b1;
        pass_d    = '0;
        state_d   = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_RUN) || (state_d == S_HOLD);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pass_q  <= '0;
      term_q  <= '0;
      rep_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      term_q  <= term_d;
      rep_q   <= rep_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign count    = cnt;
  assign pass_cnt = pass_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign state    = state_q;

endmodule
